// File: rtl/popcount18_neuron_seq.sv
// Ternary printed-neuron sequencer that time-shares one external 18-input popcount unit.
// Optional macro POPCOUNT_PIPE_REG_EN registers pc_out (pc_q) and adds a TAIL state.
module popcount18_neuron_seq #(
    parameter int ACC_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [17:0]             in_pos,
    input  logic [17:0]             in_neg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] threshold,
    output logic [17:0]             pc_in,
    input  logic [4:0]              pc_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_act,
    output logic signed [ACC_W-1:0] out_sum
);

    typedef enum logic [2:0] {
        IDLE,
        POS,
        NEG,
`ifdef POPCOUNT_PIPE_REG_EN
        TAIL,
`endif
        DONE
    } state_t;

    // Wide enough that acc +/- 31 can never overflow before clamping.
    localparam int SW = ACC_W + 6;
    localparam logic signed [SW-1:0] ACC_MAX = SW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX - SW'(1);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, thr_reg, acc_sat;
    logic [17:0]             pos_reg, neg_reg;
    logic                    last_reg, first;
    logic [4:0]              pc_sel;
    logic                    acc_upd, acc_sub;
    logic signed [SW-1:0]    acc_ext, pc_ext, sum_ext;

`ifdef POPCOUNT_PIPE_REG_EN
    logic [4:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_out;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        pc_in     = '0;
        out_valid = 1'b0;
        acc_upd   = 1'b0;
        acc_sub   = 1'b0;
        pc_sel    = pc_out;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = POS;
            end
            POS: begin
                pc_in     = pos_reg;
`ifndef POPCOUNT_PIPE_REG_EN
                acc_upd   = 1'b1;
`endif
                state_nxt = NEG;
            end
`ifdef POPCOUNT_PIPE_REG_EN
            // The positive count captured during POS is folded in here.
            NEG: begin
                pc_in     = neg_reg;
                acc_upd   = 1'b1;
                pc_sel    = pc_q;
                state_nxt = TAIL;
            end
            TAIL: begin
                acc_upd   = 1'b1;
                acc_sub   = 1'b1;
                pc_sel    = pc_q;
                state_nxt = last_reg ? DONE : IDLE;
            end
`else
            NEG: begin
                pc_in     = neg_reg;
                acc_upd   = 1'b1;
                acc_sub   = 1'b1;
                state_nxt = last_reg ? DONE : IDLE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Popcount is unsigned (approximate units may report up to 31).
    always_comb begin
        acc_ext = SW'(acc);
        pc_ext  = $signed(SW'(pc_sel));
        sum_ext = acc_sub ? (acc_ext - pc_ext) : (acc_ext + pc_ext);
        if (sum_ext > ACC_MAX)      acc_sat = ACC_MAX[ACC_W-1:0];
        else if (sum_ext < ACC_MIN) acc_sat = ACC_MIN[ACC_W-1:0];
        else                        acc_sat = sum_ext[ACC_W-1:0];
    end

    assign out_sum = out_valid ? acc : '0;
    assign out_act = out_valid && (acc >= thr_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            thr_reg  <= '0;
            pos_reg  <= '0;
            neg_reg  <= '0;
            last_reg <= 1'b0;
            first    <= 1'b1;
        end else if (state == IDLE && in_valid) begin
            pos_reg  <= in_pos;
            neg_reg  <= in_neg;
            last_reg <= in_last;
            // Threshold belongs to the neuron, so only its first chunk sets it.
            if (first) begin
                thr_reg <= threshold;
                acc     <= '0;
                first   <= 1'b0;
            end
        end else if (acc_upd) begin
            acc <= acc_sat;
        end else if (state == DONE && out_ready) begin
            acc   <= '0;
            first <= 1'b1;
        end
    end

endmodule

// File: doc/popcount18_neuron_seq.md
# popcount18_neuron_seq

Sequencer for one ternary printed neuron built around a single shared 18-input popcount unit (exact or any approximate popcount18 variant). It accepts a stream of 18-bit positive/negative weight-masked input chunks, time-multiplexes the external popcount unit between the positive and negative halves, and accumulates the signed difference. When the last chunk arrives it compares the sum against a threshold and presents the activation on a ready/valid output.

## Interface
- ACC_W, 10: accumulator width; signed range −2^(ACC_W−1) .. 2^(ACC_W−1)−1
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input chunk valid
- in_ready  output  1  chunk accepted when in_valid && in_ready
- in_pos  input  18  positive-weight input bits of chunk
- in_neg  input  18  negative-weight input bits of chunk
- in_last  input  1  final chunk of the neuron
- threshold  input  ACC_W  signed threshold, sampled on the first accepted chunk of a neuron
- pc_in  output  18  vector driven to the external popcount unit
- pc_out  input  5  popcount result from the external unit (combinational w.r.t. pc_in)
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_act  output  1  1 when out_sum >= threshold (signed)
- out_sum  output  ACC_W  signed accumulated sum

## Operation
- States: IDLE, POS, NEG, TAIL (only with macro), DONE.
- IDLE: in_ready=1, pc_in=0. On accept: register in_pos, in_neg, in_last; if no chunk of the current neuron yet accepted, register threshold and clear acc; go POS.
- POS: pc_in=pos_reg; acc ← sat(acc + pc_out); go NEG.
- NEG: pc_in=neg_reg; acc ← sat(acc − pc_out); go DONE if last_reg else IDLE.
- DONE: out_valid=1, out_sum=acc, out_act=(acc >= thr_reg); outputs stable while out_valid && !out_ready. On handshake: clear acc, first-chunk flag set, go IDLE.
- pc_out treated as unsigned 0..31 (approximate units may exceed 18); zero-extended before add.
- Saturation: acc clamps at the signed max/min of ACC_W; no wrap-around.
- in_ready=0 in every state except IDLE; in_valid ignored outside IDLE.
- Reset (any time, including mid-neuron or during DONE): state=IDLE, acc=0, thr_reg=0, pos_reg/neg_reg/last_reg=0, first-chunk flag=1; in_ready=1, out_valid=0, out_act=0, out_sum=0, pc_in=0. Partial neuron is discarded.

## Timing
- Without macro: 3 cycles per chunk (IDLE accept, POS, NEG); max 1 chunk per 3 cycles.
- Single-chunk neuron: accept at cycle 0 → out_valid rises at cycle 3 edge (visible in cycle 3).
- N-chunk neuron, back-to-back input: out_valid visible at cycle 3N.
- out_valid may be held indefinitely; no new chunk accepted until result handshake.
- pc_in changes only on clock edges; pc_out is sampled the same cycle it is driven.

## Configuration
- POPCOUNT_PIPE_REG_EN defined: pc_out is captured in internal register pc_q each cycle; POS drives pos_reg; NEG drives neg_reg and adds pc_q; TAIL drives 0 and subtracts pc_q, then DONE/IDLE. 4 cycles per chunk; single-chunk latency 4. Allows a registered/slow popcount unit in the path.
- Not defined: no pc_q, no TAIL state, behaviour as in Operation.

## Test plan
- Reset: assert rst_n=0 mid-POS with acc≠0 → immediately out_valid=0, in_ready=1, pc_in=0; after release, next neuron starts from acc=0.
- Single chunk, exact popcount model: in_pos=18'h3FFFF, in_neg=18'h00003, threshold=10, last=1 → out_sum=16, out_act=1, out_valid at cycle 3.
- Three chunks: pos counts 5,7,2, neg counts 9,1,6, threshold=0 → out_sum=−2, out_act=0, out_valid at cycle 9; threshold sampled only on chunk 1 (change it on chunk 2, result unchanged).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → out_valid/out_sum/out_act stable, in_ready=0, no chunk consumed; release → IDLE, next chunk accepted next cycle.
- Saturation, ACC_W=6: approximate model returning 31 for pos and 0 for neg, 3 chunks → out_sum=31 (max), not wrapped; reverse (neg=31) → out_sum=−32.
- POPCOUNT_PIPE_REG_EN build: repeat single-chunk case → out_sum=16, out_valid at cycle 4; pc_in sequence pos, neg, 0.
